// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RV32 control FSM sharing one memory port between fetch and data access.
module multicycle_controller #(
  parameter bit ENABLE_IMM_ALU = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  typedef enum logic [2:0] {C_R, C_LOAD, C_STORE, C_BRANCH, C_IMM, C_ILL} cls_t;
  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls;
  logic             retire, taken;
  logic [6:0]       op;
  logic [CNT_W-1:0] instret_q;
  logic             unused_bits;
  assign op          = instruction[6:0];
  assign taken       = zero ^ instruction[12];
  assign unused_bits = ^{instruction[31:13], instruction[11:7]};
  assign dec_cls = (op == 7'b0110011) ? C_R :
                   (op == 7'b0000011) ? C_LOAD :
                   (op == 7'b0100011) ? C_STORE :
                   (op == 7'b1100011) ? C_BRANCH :
                   (ENABLE_IMM_ALU && op == 7'b0010011) ? C_IMM : C_ILL;
  assign instret = instret_q;
  assign state   = state_q;
  // Every control output is gated by rst so the memory request drops the instant reset asserts.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          state_d  = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          cls_d   = dec_cls;
          state_d = (dec_cls == C_ILL) ? TRAP : EXEC;
        end
        EXEC: begin
          alu_op   = (cls_q == C_R) ? 2'b10 : (cls_q == C_IMM) ? 2'b11 : (cls_q == C_BRANCH) ? 2'b01 : 2'b00;
          alu_src  = cls_q inside {C_IMM, C_LOAD, C_STORE};
          pc_write = (cls_q == C_BRANCH) && taken;
          pc_src   = (cls_q == C_BRANCH) && taken;
          retire   = (cls_q == C_BRANCH);
          state_d  = (cls_q inside {C_R, C_IMM}) ? WB : (cls_q inside {C_LOAD, C_STORE}) ? MEM : FETCH;
        end
        MEM: begin
          mem_req   = 1'b1;
          i_or_d    = 1'b1;
          mem_read  = (cls_q == C_LOAD);
          mem_write = (cls_q == C_STORE);
          retire    = mem_ready && (cls_q != C_LOAD);
          state_d   = !mem_ready ? MEM : (cls_q == C_LOAD) ? WB : FETCH;
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == C_LOAD);
          retire     = 1'b1;
          state_d    = FETCH;
        end
        TRAP: illegal = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      cls_q     <= C_R;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction cycle traces built from the instruction rules, checked on two configurations.
module tb_multicycle_controller;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] a_ins = '0, b_ins = '0;
  logic a_z = 1'b0, b_z = 1'b0, a_rdy = 1'b0, b_rdy = 1'b0;
  logic a_req, a_rd, a_wr, a_iod, a_irw, a_pcw, a_pcs, a_asrc, a_rw, a_m2r, a_ill;
  logic b_req, b_rd, b_wr, b_iod, b_irw, b_pcw, b_pcs, b_asrc, b_rw, b_m2r, b_ill;
  logic [1:0] a_aop, b_aop;
  logic [2:0] a_st, b_st;
  logic [31:0] a_cnt;
  logic [3:0] b_cnt;
  multicycle_controller dut_a (
    .clk(clk), .rst(rst), .instruction(a_ins), .zero(a_z), .mem_ready(a_rdy),
    .mem_req(a_req), .mem_read(a_rd), .mem_write(a_wr), .i_or_d(a_iod), .ir_write(a_irw),
    .pc_write(a_pcw), .pc_src(a_pcs), .alu_op(a_aop), .alu_src(a_asrc), .reg_write(a_rw),
    .mem_to_reg(a_m2r), .illegal(a_ill), .instret(a_cnt), .state(a_st)
  );
  multicycle_controller #(.ENABLE_IMM_ALU(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .instruction(b_ins), .zero(b_z), .mem_ready(b_rdy),
    .mem_req(b_req), .mem_read(b_rd), .mem_write(b_wr), .i_or_d(b_iod), .ir_write(b_irw),
    .pc_write(b_pcw), .pc_src(b_pcs), .alu_op(b_aop), .alu_src(b_asrc), .reg_write(b_rw),
    .mem_to_reg(b_m2r), .illegal(b_ill), .instret(b_cnt), .state(b_st)
  );
  typedef struct {bit rdy; logic [15:0] e;} cyc_t;
  cyc_t q[$];
  int vec = 0, bad = 0;
  logic [31:0] exp_a = '0;
  logic [3:0]  exp_b = '0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] mk(logic [2:0] st, bit req, bit rd, bit wr, bit iod, bit irw, bit pcw,
                                     bit pcs, logic [1:0] aop, bit asrc, bit rw, bit m2r, bit ill);
    return {req, rd, wr, iod, irw, pcw, pcs, aop, asrc, rw, m2r, ill, st};
  endfunction
  function automatic logic [15:0] obs(bit s);
    return s ? {b_req, b_rd, b_wr, b_iod, b_irw, b_pcw, b_pcs, b_aop, b_asrc, b_rw, b_m2r, b_ill, b_st}
             : {a_req, a_rd, a_wr, a_iod, a_irw, a_pcw, a_pcs, a_aop, a_asrc, a_rw, a_m2r, a_ill, a_st};
  endfunction
  // 0 R, 1 LOAD, 2 STORE, 3 BRANCH, 4 IMM, 5 illegal
  function automatic int cls(logic [31:0] ins, bit en);
    logic [6:0] op = ins[6:0];
    return op == 7'h33 ? 0 : op == 7'h03 ? 1 : op == 7'h23 ? 2 : op == 7'h63 ? 3 : (en && op == 7'h13) ? 4 : 5;
  endfunction
  task automatic add(bit r, logic [15:0] e);
    q.push_back('{r, e});
  endtask
  task automatic build(logic [31:0] ins, int fw, int mw, bit z, bit en, output int c);
    bit t;
    q.delete();
    c = cls(ins, en);
    t = z ^ ins[12];
    for (int i = 0; i < fw; i++) add(1'b0, mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    add(1'b1, mk(3'd0, 1, 1, 0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 0));
    add(1'($urandom), mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    if (c == 5) begin
      for (int i = 0; i < 20; i++) add(1'($urandom), mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
      return;
    end
    case (c)
      0: add(1'($urandom), mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0));
      4: add(1'($urandom), mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd3, 1, 0, 0, 0));
      3: add(1'($urandom), mk(3'd2, 0, 0, 0, 0, 0, t, t, 2'd1, 0, 0, 0, 0));
      default: add(1'($urandom), mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0));
    endcase
    if (c == 1 || c == 2) begin
      for (int i = 0; i < mw; i++) add(1'b0, mk(3'd3, 1, c == 1, c == 2, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0));
      add(1'b1, mk(3'd3, 1, c == 1, c == 2, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0));
    end
    if (c == 0 || c == 1 || c == 4) add(1'($urandom), mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1, c == 1, 0));
  endtask
  // Replays the first n cycles of the trace (all when n<0); instruction is garbage while fetching.
  task automatic play(bit s, logic [31:0] ins, bit z, int n, string tag);
    int lim = (n < 0) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (s) begin
        b_ins = (q[i].e[2:0] == 3'd0) ? $urandom : ins; b_rdy = q[i].rdy; b_z = z;
      end else begin
        a_ins = (q[i].e[2:0] == 3'd0) ? $urandom : ins; a_rdy = q[i].rdy; a_z = z;
      end
      #1;
      chk({tag, "/ctl"}, 32'(obs(s)), 32'(q[i].e));
      chk({tag, "/cnt"}, s ? 32'(b_cnt) : a_cnt, s ? 32'(exp_b) : exp_a);
    end
  endtask
  task automatic instr(bit s, logic [31:0] ins, int fw, int mw, bit z, string tag);
    int c;
    build(ins, fw, mw, z, !s, c);
    play(s, ins, z, -1, tag);
    if (c != 5) begin
      if (s) exp_b = exp_b + 4'd1;
      else exp_a = exp_a + 32'd1;
    end
  endtask
  task automatic do_rst(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, "/a_ctl"}, 32'(obs(0)), 32'd0);
    chk({tag, "/b_ctl"}, 32'(obs(1)), 32'd0);
    chk({tag, "/a_cnt"}, a_cnt, 32'd0);
    chk({tag, "/b_cnt"}, 32'(b_cnt), 32'd0);
    exp_a = '0; exp_b = '0;
    @(negedge clk);
    rst = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
    #1;
    chk({tag, "/a_fetch"}, 32'(obs(0)), 32'(mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0)));
  endtask
  initial begin
    int c;
    logic [31:0] ops[5] = '{32'h33, 32'h03, 32'h23, 32'h63, 32'h13};
    logic [31:0] ins;
    do_rst("por");
    instr(0, 32'h002081B3, 0, 0, 0, "add");
    instr(0, 32'h0000A103, 0, 2, 0, "lw");
    instr(0, 32'h00208463, 0, 0, 1, "beq_z1");
    instr(0, 32'h00208463, 1, 0, 0, "beq_z0");
    instr(0, 32'h00209463, 0, 0, 1, "bne_z1");
    instr(0, 32'h00209463, 2, 0, 0, "bne_z0");
    instr(0, 32'h00108093, 0, 0, 0, "addi_en");
    for (int k = 0; k < 60; k++) begin
      ins = {$urandom} & 32'hFFFF_FF80 | ops[$urandom_range(0, 4)];
      instr(0, ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), "rnd");
    end
    build(32'h0000A103, 1, 3, 0, 1'b1, c);
    play(0, 32'h0000A103, 0, 5, "lw_abort");
    do_rst("mem_abort");
    instr(0, 32'h002081B3, 0, 1, 0, "restart");
    instr(0, 32'h0000007F, 1, 0, 0, "trap");
    do_rst("trap_clr");
    instr(1, 32'h00108093, 0, 0, 0, "addi_dis");
    do_rst("b_clr");
    for (int k = 0; k < 17; k++)
      instr(1, {$urandom} & 32'hFFFF_FF80 | 32'h23, $urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom), "sw_wrap");
    @(negedge clk);
    b_rdy = 1'b0;
    #1 chk("wrap_cnt", 32'(b_cnt), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
